firmware_loader: RTL and testbench

Bus initiator that streams firmware into on-chip BRAM over the same mem_valid/mem_ready/mem_wstrb memory protocol the CPU uses. It accepts bytes from a byte-stream source (e.g. UART receiver), packs them little-endian into 32-bit words, and issues one full-word write transaction per word at consecutive addresses. It holds the CPU in reset while loading and releases it on completion, which lets a seed bitstream be reprogrammed without a rebuild.

---
 rtl/firmware_loader_pkg.sv | 30 +++
 rtl/firmware_loader_byte_packer.sv | 37 +++
 rtl/firmware_loader.sv | 164 ++++++++++++++++
 tb/tb_firmware_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firmware_loader_pkg.sv
// Shared types and constants for the firmware loader and the BRAM controller
// that answers its write/read transactions.
package firmware_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_READ,
    ST_FINISH
  } state_t;

  localparam logic [3:0]  MEM_WSTRB_WORD = 4'b1111;
  localparam logic [3:0]  MEM_WSTRB_READ = 4'b0000;
  localparam logic [31:0] WORD_ADDR_INC  = 32'd4;

  // Wide enough to count up to and including 65536 words.
  localparam int INDEX_W = 17;

  // Little-endian lane insert: byte lane n lands in bits [8n+7:8n].
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/firmware_loader_byte_packer.sv
// Collects four stream bytes into one little-endian word; word_valid pulses
// combinationally with the acceptance of the fourth byte.
module loader_byte_packer
  import firmware_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;
  logic        accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'd0;
    end else if (accept) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      word_reg     <= insert_byte(word_reg, byte_cnt_reg, in_data);
    end
  end

  // The completed word includes the byte being accepted right now, so the
  // loader can register it on the same edge without an extra cycle.
  assign word       = insert_byte(word_reg, byte_cnt_reg, in_data);
  assign word_valid = accept && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/firmware_loader.sv
// Streams bytes into BRAM as full-word writes and holds the CPU in reset while
// loading. Define FIRMWARE_LOADER_READBACK_EN to verify every word by read-back.
module firmware_loader
  import firmware_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_reset_n
);

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  state_t             state_reg;
  logic [INDEX_W-1:0] word_count_reg;
  logic [INDEX_W-1:0] index_reg;
  logic [INDEX_W-1:0] index_next;
  logic [31:0]        word_addr_reg;

  logic [31:0]        packed_word;
  logic               packed_valid;
  logic               pack_clear;

  assign index_next = index_reg + 17'd1;
  assign pack_clear = (state_reg == ST_IDLE);

  loader_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .word       (packed_word),
    .word_valid (packed_valid)
  );

`ifndef FIRMWARE_LOADER_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      word_count_reg <= '0;
      index_reg      <= '0;
      word_addr_reg  <= BASE_ADDR;
      in_ready       <= 1'b0;
      mem_valid      <= 1'b0;
      mem_addr       <= BASE_ADDR;
      mem_wdata      <= 32'd0;
      mem_wstrb      <= MEM_WSTRB_READ;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_reset_n    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            word_count_reg <= word_count[INDEX_W-1:0];
            index_reg      <= '0;
            word_addr_reg  <= BASE_ADDR;
            done           <= 1'b0;
            error          <= 1'b0;
            busy           <= 1'b1;
            cpu_reset_n    <= 1'b0;
            if (word_count == 32'd0) begin
              state_reg <= ST_FINISH;
            end else if (word_count > MAX_WORDS_U) begin
              // Oversized image: refuse it without touching the bus.
              error     <= 1'b1;
              state_reg <= ST_FINISH;
            end else begin
              in_ready  <= 1'b1;
              state_reg <= ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          if (packed_valid) begin
            in_ready  <= 1'b0;
            mem_valid <= 1'b1;
            mem_wstrb <= MEM_WSTRB_WORD;
            mem_addr  <= word_addr_reg;
            mem_wdata <= packed_word;
            state_reg <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          if (mem_valid && mem_ready) begin
            mem_valid     <= 1'b0;
            index_reg     <= index_next;
            word_addr_reg <= word_addr_reg + WORD_ADDR_INC;
`ifdef FIRMWARE_LOADER_READBACK_EN
            state_reg     <= ST_READ;
`else
            if (index_next == word_count_reg) begin
              state_reg <= ST_FINISH;
            end else begin
              in_ready  <= 1'b1;
              state_reg <= ST_COLLECT;
            end
`endif
          end
        end

`ifdef FIRMWARE_LOADER_READBACK_EN
        // mem_addr and mem_wdata still hold the word just written; the first
        // READ cycle is the mandatory idle gap between transactions.
        ST_READ: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_wstrb <= MEM_WSTRB_READ;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_rdata != mem_wdata) begin
              error     <= 1'b1;
              state_reg <= ST_FINISH;
            end else if (index_reg == word_count_reg) begin
              state_reg <= ST_FINISH;
            end else begin
              in_ready  <= 1'b1;
              state_reg <= ST_COLLECT;
            end
          end
        end
`endif

        ST_FINISH: begin
          in_ready    <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          cpu_reset_n <= 1'b1;
          state_reg   <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_firmware_loader.sv
// Randomized bench for firmware_loader: byte source, bus responder with a
// memory image, and a word-level reference model of the expected writes.
module tb_firmware_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 65536;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_count = 32'd0;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_reset_n;

  always #5 clk = ~clk;

  firmware_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .word_count  (word_count),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_reset_n (cpu_reset_n)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  logic [7:0]  stim_q[$];
  logic [7:0]  src_q[$];
  int          accepted_cnt = 0;
  bit          expect_valid = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_cnt = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_wr_addr = 32'd0;
  int          resp_lat = 3;
  bit          spur_en = 0;
  bit          corrupt_en = 0;
  logic [31:0] corrupt_addr = 32'd0;
  bit          saw_valid = 0;
  bit          saw_in_ready = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_stim(input int words);
    stim_q.delete();
    for (int i = 0; i < 4 * words; i++) stim_q.push_back(8'($urandom));
  endtask

  // Byte source: offers queued bytes with random gaps; a byte leaves the
  // queue only when the loader is ready for it.
  initial begin
    in_valid = 1'b0;
    in_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (expect_valid) begin
        expect_valid = 0;
        if (reset_n) check("valid_after_4th_byte", 32'(mem_valid), 32'd1);
      end
      if (reset_n && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
        if (in_ready) begin
          void'(src_q.pop_front());
          accepted_cnt++;
          if (accepted_cnt % 4 == 0) expect_valid = 1;
        end
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
  end

  // Bus responder with configurable latency and a memory image for reads.
  initial begin
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_wstrb;
    int          resp_wait;
    bit          resp_active;
    bit          spur;
    cap_addr = 0; cap_data = 0; cap_wstrb = 0; resp_wait = 0;
    resp_active = 0; spur = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem_ready = 1'b0;
        resp_active = 0;
        spur = 0;
      end else if (mem_ready && !spur) begin
        mem_ready = 1'b0;
        check("valid_drop_after_ready", 32'(mem_valid), 32'd0);
      end else begin
        mem_ready = 1'b0;
        spur = 0;
        if (mem_valid) begin
          if (!resp_active) begin
            resp_active = 1;
            cap_addr  = mem_addr;
            cap_data  = mem_wdata;
            cap_wstrb = mem_wstrb;
            if (resp_lat < 0) resp_wait = int'($urandom_range(0, 4));
            else resp_wait = resp_lat;
            check("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
`ifdef FIRMWARE_LOADER_READBACK_EN
            if (mem_wstrb == 4'h0) check("read_addr", mem_addr, last_wr_addr);
`else
            check("wstrb_write", 32'(mem_wstrb), 32'hF);
`endif
          end else begin
            check("hold_addr", mem_addr, cap_addr);
            check("hold_wstrb", 32'(mem_wstrb), 32'(cap_wstrb));
            if (cap_wstrb == 4'hF) check("hold_wdata", mem_wdata, cap_data);
          end
          check("in_ready_during_bus", 32'(in_ready), 32'd0);
          if (resp_wait == 0) begin
            mem_ready = 1'b1;
            resp_active = 0;
            if (cap_wstrb == 4'hF) begin
              wr_addr_q.push_back(cap_addr);
              wr_data_q.push_back(cap_data);
              mem_model[cap_addr] = cap_data;
              last_wr_addr = cap_addr;
              $display("bus write addr=0x%08h data=0x%08h", cap_addr, cap_data);
            end else begin
              rd_cnt++;
              mem_rdata = mem_model.exists(cap_addr) ? mem_model[cap_addr] : 32'd0;
              if (corrupt_en && cap_addr == corrupt_addr) mem_rdata = mem_rdata ^ 32'd1;
              $display("bus read  addr=0x%08h data=0x%08h", cap_addr, mem_rdata);
            end
          end else begin
            resp_wait--;
          end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
          mem_ready = 1'b1;
          spur = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_valid) saw_valid = 1;
        if (in_ready) saw_in_ready = 1;
        check("cpu_reset_vs_busy", 32'(cpu_reset_n), 32'(!busy));
      end
    end
  end

  // One complete load; expected writes come from stim_q by plain byte packing.
  task automatic run_load(input string name, input logic [31:0] wc, input bit poke);
    int   exp_n;
    bit   exp_err;
    bit   normal;
    int   cyc;
    int   limit;
    logic [31:0] exp_word;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cnt = 0;
    accepted_cnt = 0;
    saw_valid = 0;
    saw_in_ready = 0;
    exp_err = (wc > MAXW);
    exp_n   = exp_err ? 0 : int'(wc);
    normal  = !exp_err && (wc != 32'd0);
`ifdef FIRMWARE_LOADER_READBACK_EN
    if (corrupt_en) begin
      for (int i = 0; i < exp_n; i++) begin
        if (BASE + 32'(4 * i) == corrupt_addr) begin
          exp_n = i + 1;
          exp_err = 1;
          break;
        end
      end
    end
`endif
    src_q = stim_q;
    start = 1'b1;
    word_count = wc;
    tick(1);
    start = 1'b0;
    word_count = $urandom;
    check({name, "_done_cleared"}, 32'(done), 32'd0);
    if (normal) begin
      check({name, "_busy_set"}, 32'(busy), 32'd1);
      check({name, "_cpu_held"}, 32'(cpu_reset_n), 32'd0);
    end
    cyc = 1;
    limit = 300 + 40 * exp_n;
    while (!done && cyc < limit) begin
      if (poke && cyc == 6 && busy) begin
        start = 1'b1;
        word_count = 32'd1;
      end else begin
        start = 1'b0;
      end
      tick(1);
      cyc++;
    end
    start = 1'b0;
    check({name, "_done"}, 32'(done), 32'd1);
    if (!normal) check({name, "_done_latency_le2"}, 32'(cyc <= 2), 32'd1);
    tick(4);
    check({name, "_done_sticky"}, 32'(done), 32'd1);
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_cpu_released"}, 32'(cpu_reset_n), 32'd1);
    check({name, "_write_count"}, 32'(wr_addr_q.size()), 32'(exp_n));
    check({name, "_bytes_taken"}, 32'(accepted_cnt), 32'(4 * exp_n));
`ifdef FIRMWARE_LOADER_READBACK_EN
    check({name, "_read_count"}, 32'(rd_cnt), 32'(exp_n));
`else
    check({name, "_read_count"}, 32'(rd_cnt), 32'd0);
`endif
    for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
      exp_word = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
      check({name, "_wr_addr"}, wr_addr_q[i], BASE + 32'(4 * i));
      check({name, "_wr_data"}, wr_data_q[i], exp_word);
    end
    if (!normal) begin
      check({name, "_no_bus"}, 32'(saw_valid), 32'd0);
      check({name, "_no_in_ready"}, 32'(saw_in_ready), 32'd0);
    end
    src_q.delete();
    $display("load %s wc=%0d writes=%0d error=%0d cycles=%0d", name, wc, wr_addr_q.size(), error, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    tick(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    reset_n = 1'b1;
    tick(1);

    // Two words through a 3-wait responder.
    resp_lat = 3;
    stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("two_words", 32'd2, 0);
    if (wr_data_q.size() == 2) begin
      check("two_words_w0", wr_data_q[0], 32'h1234_5678);
      check("two_words_w1", wr_data_q[1], 32'hDEAD_BEEF);
    end

    gen_stim(1);
    run_load("zero_count", 32'd0, 0);
    gen_stim(1);
    run_load("oversize", 32'd65537, 0);

    resp_lat = 10;
    gen_stim(1);
    run_load("slow_ready", 32'd1, 0);

    // Reset while a write is outstanding.
    resp_lat = 20;
    gen_stim(3);
    src_q = stim_q;
    start = 1'b1;
    word_count = 32'd3;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (!mem_valid && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("mid_reset_reached_write", 32'(mem_valid), 32'd1);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    check("mid_reset_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    src_q.delete();
    tick(1);
    reset_n = 1'b1;
    tick(1);
    resp_lat = 2;
    gen_stim(1);
    run_load("after_reset", 32'd1, 0);

    // Randomized loads, random latency, stray mem_ready and ignored starts.
    resp_lat = -1;
    spur_en = 1;
    for (int r = 0; r < 6; r++) begin
      gen_stim(int'($urandom_range(1, 6)));
      run_load("random", 32'(stim_q.size() / 4), r[0]);
    end
    spur_en = 0;

`ifdef FIRMWARE_LOADER_READBACK_EN
    resp_lat = 3;
    corrupt_en = 1;
    corrupt_addr = BASE;
    stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("readback_bad_w0", 32'd2, 0);
    corrupt_addr = BASE + 32'd8;
    resp_lat = -1;
    gen_stim(5);
    run_load("readback_bad_w2", 32'd5, 0);
    corrupt_en = 0;
    gen_stim(3);
    run_load("readback_good", 32'd3, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
